imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: the CPU only reads instructions by PC, and this block fills that memory.
- Receives a framed byte stream (from a UART receiver or debug port) and assembles 32-bit instructions. It writes them into instruction memory at word-aligned byte addresses compatible with PC stepping by 4.
- Holds the CPU in reset until a complete, checksum-verified image has been written.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/byte_to_word_packer.sv | 41 ++++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA/loader definitions: instruction width, word size, default load
// address and the loader state encoding.
package isa_pkg;

  localparam int          INST_WIDTH        = 32;
  localparam int          WORD_BYTES        = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t S_LEN_HI = 3'd0;
  localparam loader_state_t S_LEN_LO = 3'd1;
  localparam loader_state_t S_WORD   = 3'd2;
  localparam loader_state_t S_WRITE  = 3'd3;
  localparam loader_state_t S_CSUM   = 3'd4;
  localparam loader_state_t S_DONE   = 3'd5;
  localparam loader_state_t S_ERR    = 3'd6;

  // Byte address of instruction slot 'index' (PC steps by 4).
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] index);
    return base + {14'd0, index, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
  import isa_pkg::*;

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [31:0]           imem_addr;
  logic [INST_WIDTH-1:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/byte_to_word_packer.sv
// Shifts accepted bytes MSB-first into an instruction word and pulses
// word_valid the cycle after the last byte of a word.
module byte_to_word_packer
  import isa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_data,
  output logic [INST_WIDTH-1:0] word,
  output logic                  last_byte,
  output logic                  word_valid
);

  localparam int                IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0] idx;

  assign last_byte = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      // Word contents are left alone; only the framing restarts.
      idx        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift_en && last_byte;
      if (shift_en) begin
        word <= {word[INST_WIDTH-9:0], byte_data};
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length/words/checksum byte frame,
// writes words to imem and holds the CPU in reset until a verified load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LEN_HI | waiting for word-count high byte
// S_LEN_LO | waiting for word-count low byte; range check
// S_WORD   | collecting the 4 bytes of one instruction
// S_WRITE  | one-cycle imem write of the assembled word
// S_CSUM   | waiting for XOR checksum byte
// S_DONE   | image verified, CPU released (terminal until reload)
// S_ERR    | oversize header or bad checksum (terminal until reload)
module imem_loader
  import isa_pkg::*;
#(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
)(
  input  logic                 clk,
  input  logic                 rst,
  imem_loader_if.master        bus,
  input  logic                 reload,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          word_count
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  loader_state_t         state;
  loader_state_t         state_next;
  logic [15:0]           len;
  logic [15:0]           len_rx;
  logic [7:0]            csum;
  logic                  receiving;
  logic                  accept;
  logic                  last_byte;
  logic                  word_valid;
  logic [INST_WIDTH-1:0] asm_word;

  assign len_rx = {len[15:8], bus.byte_data};

  always_comb begin
    receiving = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                (state == S_WORD)   || (state == S_CSUM);
  end

  // reload wins over an offered byte so that byte is never consumed.
  assign bus.byte_ready = !rst && !reload && receiving;
  assign accept         = bus.byte_valid && bus.byte_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_rx > MAX_N)       state_next = S_ERR;
          else if (len_rx == 16'd0) state_next = S_CSUM;
          else                      state_next = S_WORD;
        end
      end
      S_WORD:   if (accept && last_byte) state_next = S_WRITE;
      S_WRITE:  state_next = (word_count + 16'd1 == len) ? S_CSUM : S_WORD;
      S_CSUM: begin
        if (accept) state_next = (bus.byte_data == csum) ? S_DONE : S_ERR;
      end
      default:  state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN_HI;
      len        <= '0;
      csum       <= '0;
      word_count <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (reload) begin
      state      <= S_LEN_HI;
      csum       <= '0;
      word_count <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state    <= state_next;
      // Registered so the CPU reset releases cleanly on an edge.
      cpu_hold <= (state_next != S_DONE);
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERR);
      if (accept && (state != S_CSUM)) csum <= csum ^ bus.byte_data;
      if (accept && (state == S_LEN_HI)) len[15:8] <= bus.byte_data;
      if (accept && (state == S_LEN_LO)) len[7:0]  <= bus.byte_data;
      if (state == S_WRITE) word_count <= word_count + 16'd1;
    end
  end

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (reload),
    .shift_en   (accept && (state == S_WORD)),
    .byte_data  (bus.byte_data),
    .word       (asm_word),
    .last_byte  (last_byte),
    .word_valid (word_valid)
  );

  // Address follows word_count, so reload and rst both restart at BASE_ADDR.
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = word_addr(BASE_ADDR, word_count);
  assign bus.imem_wdata = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole frames plus reset and
// reload-collision sequences.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        reload;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_loader_if bus ();

  imem_loader #(.MAX_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reload     (reload),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  typedef struct {
    string       name;
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    int          gap;
    bit          body;
    bit          exp_done;
    bit          exp_error;
    int          exp_writes;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reload = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    #1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.byte_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: byte %h never accepted", b);
      bus.byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic chk_writes(input string tag, input int cnt, input logic [31:0] w0, input logic [31:0] w1);
    chk({tag, "_nwrites"}, wr_addr.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      if (i < wr_addr.size()) begin
        chk({tag, "_addr"}, wr_addr[i], 32'(i * 4));
        chk({tag, "_data"}, wr_data[i], (i == 0) ? w0 : w1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"n2_ok",      16'd2,     32'hE3A01005, 32'h0, 8'h54, 0, 1'b1, 1'b1, 1'b0, 2, 16'd2};
    vecs[1] = '{"n2_badcsum", 16'd2,     32'hE3A01005, 32'h0, 8'h55, 0, 1'b1, 1'b0, 1'b1, 2, 16'd2};
    vecs[2] = '{"n_over",     16'h0401,  32'h0,        32'h0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 0, 16'd0};
    vecs[3] = '{"n0",         16'd0,     32'h0,        32'h0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 0, 16'd0};
    vecs[4] = '{"n1_gappy",   16'd1,     32'hE3A01005, 32'h0, 8'h57, 1, 1'b1, 1'b1, 1'b0, 1, 16'd1};
    vecs[5] = '{"n1_b2b",     16'd1,     32'hE3A01005, 32'h0, 8'h57, 0, 1'b1, 1'b1, 1'b0, 1, 16'd1};

    // Reset state
    rst = 1'b1;
    reload = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.byte_ready, 1'b0);
    chk("rst_we", bus.imem_we, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_wdata", bus.imem_wdata, 32'h0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_wc", word_count, 16'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", bus.byte_ready, 1'b1);

    foreach (vecs[k]) begin
      vec_t v;
      logic [15:0] nn;
      v = vecs[k];
      nn = v.n;
      do_reset();
      send_byte(nn[15:8], v.gap);
      send_byte(nn[7:0], v.gap);
      if (v.body) begin
        for (int w = 0; w < int'(v.n); w++)
          send_word((w == 0) ? v.w0 : v.w1, v.gap);
        send_byte(v.csum, v.gap);
      end
      if (v.gap == 0) begin
        chk({v.name, "_done"}, done, v.exp_done);
        chk({v.name, "_error"}, error, v.exp_error);
        chk({v.name, "_hold"}, cpu_hold, !v.exp_done);
      end
      repeat (3) @(negedge clk);
      chk({v.name, "_done_sticky"}, done, v.exp_done);
      chk({v.name, "_error_sticky"}, error, v.exp_error);
      chk({v.name, "_hold_sticky"}, cpu_hold, !v.exp_done);
      chk({v.name, "_wc"}, word_count, v.exp_wc);
      chk({v.name, "_ready_end"}, bus.byte_ready, 1'b0);
      chk_writes(v.name, v.exp_writes, v.w0, v.w1);
    end

    // Reload collides with a byte after two bytes of word 0
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hE3, 0);
    send_byte(8'hA0, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h10;
    reload = 1'b1;
    #1;
    chk("reload_ready", bus.byte_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reload = 1'b0;
    bus.byte_valid = 1'b0;
    chk("reload_hold", cpu_hold, 1'b1);
    chk("reload_wc", word_count, 16'd0);
    chk("reload_done", done, 1'b0);
    chk("reload_addr", bus.imem_addr, 32'h0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hE3A01005, 0);
    send_word(32'h00000000, 0);
    send_byte(8'h54, 0);
    chk("reload_frame_done", done, 1'b1);
    chk("reload_frame_hold", cpu_hold, 1'b0);
    chk("reload_frame_error", error, 1'b0);
    chk_writes("reload_frame", 2, 32'hE3A01005, 32'h00000000);

    // Reload out of the error state re-arms the loader
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk("err_then_reload_error", error, 1'b1);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("err_reload_cleared", error, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("err_reload_n0_done", done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
